handshake_const_check: RTL and testbench
========================================

HANDSHAKE_CONST_CHECK -- requirements
Module: handshake_const_check

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data input channel.
REQ-002 Parameter CONST_VALUE, default all-zero DATA_WIDTH vector: value each incoming token is compared against.
REQ-003 Parameter CNT_WIDTH, default 16: width of the accepted-token counter.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 rst  input  1: synchronous, active-low reset; rst==0 at a rising edge resets the block.
REQ-007 ins  input  DATA_WIDTH: input data token.
REQ-008 ins_valid  input  1: input token present.
REQ-009 ins_ready  output  1: block accepts the token this cycle.
REQ-010 outs  output  1: result token, 1 = token equalled CONST_VALUE.
REQ-011 outs_valid  output  1: result token present.
REQ-012 outs_ready  input  1: downstream accepts the result token.
REQ-013 mismatch_seen  output  1: sticky flag, set after any accepted token differs from CONST_VALUE.
REQ-014 token_count  output  CNT_WIDTH: number of accepted input tokens, saturating.

Function
REQ-015 An input transfer SHALL occur on a cycle with ins_valid && ins_ready; an output transfer SHALL occur on a cycle with outs_valid && outs_ready.
REQ-016 The result for each accepted token SHALL be (ins == CONST_VALUE), compared over the full DATA_WIDTH with no sign extension or truncation.
REQ-017 Results SHALL pass through a 2-slot FIFO with states EMPTY, ONE and FULL, in strict order, with no loss or duplication.
REQ-018 Latency SHALL be exactly 1 cycle: a token accepted at edge N SHALL present outs_valid=1 after edge N when the FIFO was EMPTY.
REQ-019 ins_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL be a registered function of state only, with no combinational path from outs_ready.
REQ-020 outs_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY; outs SHALL show the oldest slot.
REQ-021 State transitions SHALL be as follows.
- EMPTY: push only -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, with the new result replacing the popped one.
- FULL: pop -> ONE (no push possible).
- Otherwise the state SHALL hold.
REQ-022 With ins_valid and outs_ready held at 1, throughput SHALL be one token per cycle.
REQ-023 While outs_valid=1 and outs_ready=0, outs SHALL remain stable.
REQ-024 token_count SHALL increment by 1 per input transfer and saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-025 mismatch_seen SHALL be set on the edge that accepts a non-matching token and SHALL clear only on reset.
REQ-026 ins SHALL be ignored whenever no input transfer occurs.

Reset
REQ-027 While rst==0 at an edge, the block SHALL enter EMPTY, with ins_ready=0 during the reset cycle, outs_valid=0, outs=0, token_count=0 and mismatch_seen=0.
REQ-028 A reset asserted mid-operation SHALL discard all buffered results.
REQ-029 ins_ready SHALL return to 1 on the first edge with rst==1.

Structure
REQ-030 The FIFO state encoding (EMPTY, ONE, FULL) and the default CNT_WIDTH SHALL be defined in the shared package handshake_pkg.
REQ-031 The 2-slot FIFO SHALL be a sub-module handshake_elastic_buf2, parameterised by width, containing the same reset and handshake rules.
REQ-032 The comparison, counter and sticky flag SHALL sit in handshake_const_check.

Verification
REQ-033 Streaming: CONST_VALUE=0x1F, with tokens 0x1F, 0x1F and 0x20 sent back-to-back and outs_ready=1 -> outs sequence 1, 1, 0 on consecutive cycles; token_count=3; mismatch_seen=1 after the third acceptance.
REQ-034 Backpressure: outs_ready=0 with 3 tokens offered -> 2 tokens accepted; ins_ready=0 in FULL; outs stable. Then outs_ready=1 -> results drain in order and the third token is accepted.
REQ-035 Simultaneous push and pop in ONE: state stays ONE; outs shows the new result next cycle; no drop.
REQ-036 Saturation: CNT_WIDTH=4 with 20 tokens -> token_count holds at 15.
REQ-037 Reset mid-stream: rst=0 for one cycle while FULL -> outs_valid=0, token_count=0 and mismatch_seen=0 next cycle; buffered results are never emitted.
REQ-038 Random valid/ready stress: the scoreboard SHALL match a reference model token-for-token, with no ins_ready/outs_ready combinational dependency.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake constant-check block.
//   buf_state_e       : occupancy of the 2-slot elastic buffer
//   DEFAULT_CNT_WIDTH : default width of the accepted-token counter
//   buf_can_push()    : whether a buffer in a given state can take a token
package handshake_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

  function automatic logic buf_can_push(input buf_state_e s);
    return (s != FULL);
  endfunction

endpackage

// File: rtl/handshake_elastic_buf2.sv
// Two-slot elastic buffer with valid/ready handshakes on both sides.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset, discards buffered entries
//   ins        : input entry, WIDTH bits
//   ins_valid  : input entry present
//   ins_ready  : registered, depends on buffer state only
//   outs       : oldest buffered entry
//   outs_valid : buffer holds at least one entry
//   outs_ready : downstream accepts the oldest entry
module handshake_elastic_buf2
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ins,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic [WIDTH-1:0] outs,
  output logic             outs_valid,
  input  logic             outs_ready
);

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic [WIDTH-1:0] slot0_q;   // oldest entry
  logic [WIDTH-1:0] slot1_q;   // second entry, valid only in FULL
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push       = ins_valid && ready_q;
  assign pop        = (state_q != EMPTY) && outs_ready;
  assign ins_ready  = ready_q;
  assign outs_valid = (state_q != EMPTY);
  assign outs       = slot0_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // ready is registered from the next state so that it never depends
  // combinationally on outs_ready; it is held low for the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= buf_can_push(state_d);
      unique case (state_q)
        EMPTY: if (push) slot0_q <= ins;
        ONE: begin
          if (push && pop) slot0_q <= ins;
          else if (push)   slot1_q <= ins;
        end
        FULL:    if (pop) slot0_q <= slot1_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/handshake_const_check.sv
// Compares each accepted token against CONST_VALUE and streams the
// 1-bit result through a 2-slot elastic buffer.
//   clk           : clock, rising edge
//   rst           : synchronous active-low reset
//   ins/ins_valid/ins_ready    : input token channel
//   outs/outs_valid/outs_ready : result channel, 1 = token matched
//   mismatch_seen : sticky, set once any accepted token differed
//   token_count   : accepted tokens, saturating
module handshake_const_check
  import handshake_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]  CONST_VALUE = '0,
  parameter int unsigned            CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  mismatch_seen,
  output logic [CNT_WIDTH-1:0]  token_count
);

  logic                 match;
  logic                 accept;
  logic                 mismatch_q;
  logic [CNT_WIDTH-1:0] count_q;

  assign match  = (ins == CONST_VALUE);
  assign accept = ins_valid && ins_ready;

  handshake_elastic_buf2 #(
    .WIDTH (1)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .ins        (match),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      mismatch_q <= 1'b0;
    end else if (accept) begin
      if (count_q != '1) count_q <= count_q + 1'b1;
      if (!match)        mismatch_q <= 1'b1;
    end
  end

  assign token_count   = count_q;
  assign mismatch_seen = mismatch_q;

endmodule

// File: tb/tb_handshake_const_check.sv
module tb_handshake_const_check;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 4;
  localparam logic [7:0]  CVAL = 8'h1F;
  localparam int          SAT  = 15;

  logic          clk;
  logic          rst;
  logic [DW-1:0] ins;
  logic          ins_valid;
  logic          ins_ready;
  logic          outs;
  logic          outs_valid;
  logic          outs_ready;
  logic          mismatch_seen;
  logic [CW-1:0] token_count;

  int total = 0;
  int bad   = 0;

  // scoreboard / reference model
  bit q[$];
  int cnt_m    = 0;
  bit mism_m   = 0;
  bit last_rst = 0;
  bit armed    = 0;

  handshake_const_check #(
    .DATA_WIDTH  (DW),
    .CONST_VALUE (CVAL),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ins           (ins),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .outs          (outs),
    .outs_valid    (outs_valid),
    .outs_ready    (outs_ready),
    .mismatch_seen (mismatch_seen),
    .token_count   (token_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model runs on the falling edge: first compare the DUT state produced by
  // the previous rising edge, then account for the transfers of the next one.
  always @(negedge clk) begin
    bit mrdy;
    bit mvld;
    if (armed) begin
      mrdy = !last_rst && (q.size() < 2);
      mvld = (q.size() != 0);
      check("ins_ready", ins_ready, mrdy);
      check("outs_valid", outs_valid, mvld);
      if (mvld) check("outs", outs, q[0]);
      if (last_rst) check("outs_rst", outs, 0);
      check("token_count", token_count, cnt_m);
      check("mismatch_seen", mismatch_seen, mism_m);
    end else begin
      mrdy = 0;
      mvld = 0;
    end
    if (!rst) begin
      q.delete();
      cnt_m    = 0;
      mism_m   = 0;
      last_rst = 1;
      armed    = 1;
    end else if (armed) begin
      last_rst = 0;
      if (mvld && outs_ready) void'(q.pop_front());
      if (mrdy && ins_valid) begin
        q.push_back(ins == CVAL);
        if (cnt_m < SAT) cnt_m++;
        if (ins != CVAL) mism_m = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] tok [3];
    logic [2:0]    exp_seq;
    int            idx;
    int            acc;
    logic          held;
    logic          r0;

    rst = 1'b0; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
    repeat (3) tick();
    check("rst_ins_ready", ins_ready, 0);
    check("rst_outs_valid", outs_valid, 0);
    check("rst_outs", outs, 0);
    check("rst_count", token_count, 0);
    check("rst_mism", mismatch_seen, 0);
    rst = 1'b1;
    tick();
    check("rel_ins_ready", ins_ready, 1);

    // streaming
    tok[0] = 8'h1F; tok[1] = 8'h1F; tok[2] = 8'h20;
    exp_seq = 3'b011;   // bit k = result after k-th edge
    outs_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ins = tok[k]; ins_valid = 1'b1;
      tick();
      check("strm_valid", outs_valid, 1);
      check("strm_outs", outs, exp_seq[k]);
    end
    ins_valid = 1'b0;
    check("strm_count", token_count, 3);
    check("strm_mism", mismatch_seen, 1);
    repeat (2) tick();

    // backpressure
    tok[0] = 8'h1F; tok[1] = 8'h00; tok[2] = 8'h1F;
    outs_ready = 1'b0; idx = 0;
    for (int k = 0; k < 4; k++) begin
      ins = tok[idx]; ins_valid = 1'b1;
      r0 = ins_ready;
      tick();
      if (r0) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_full_ready", ins_ready, 0);
    held = outs;
    tick();
    check("bp_stable", outs, held);
    check("bp_oldest", outs, 1);
    outs_ready = 1'b1;
    for (int k = 0; k < 10 && idx < 3; k++) begin
      r0 = ins_ready;
      tick();
      if (r0) idx++;
      if (idx < 3) ins = tok[idx];
    end
    ins_valid = 1'b0;
    check("bp_third", idx, 3);
    repeat (3) tick();

    // simultaneous push and pop in ONE
    outs_ready = 1'b0; ins = 8'h1F; ins_valid = 1'b1;
    tick();
    check("pp_one_outs", outs, 1);
    ins = 8'h00; outs_ready = 1'b1;
    tick();
    ins_valid = 1'b0;
    check("pp_valid", outs_valid, 1);
    check("pp_new", outs, 0);
    check("pp_ready", ins_ready, 1);
    tick();
    check("pp_drained", outs_valid, 0);

    // saturation
    acc = 0; ins = 8'h1F; ins_valid = 1'b1; outs_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      r0 = ins_ready;
      tick();
      if (r0) acc++;
    end
    ins_valid = 1'b0;
    check("sat_throughput", acc, 20);
    check("sat_count", token_count, SAT);
    repeat (2) tick();

    // reset while FULL
    outs_ready = 1'b0; ins = 8'h55; ins_valid = 1'b1;
    repeat (3) tick();
    check("mr_full", ins_ready, 0);
    rst = 1'b0;
    tick();
    check("mr_valid", outs_valid, 0);
    check("mr_count", token_count, 0);
    check("mr_mism", mismatch_seen, 0);
    rst = 1'b1; ins_valid = 1'b0; outs_ready = 1'b1;
    tick();
    check("mr_ready", ins_ready, 1);
    repeat (3) tick();
    check("mr_no_emit", outs_valid, 0);

    // random stress with outs_ready -> ins_ready isolation probe
    for (int k = 0; k < 400; k++) begin
      ins_valid  = ($urandom_range(0, 3) != 0);
      outs_ready = ($urandom_range(0, 2) != 0);
      ins = ($urandom_range(0, 1) != 0) ? CVAL : DW'($urandom);
      r0 = ins_ready;
      outs_ready = ~outs_ready;
      #1;
      check("comb_path", ins_ready, r0);
      outs_ready = ~outs_ready;
      tick();
    end
    ins_valid = 1'b0; outs_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
